// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared definitions for the one-hot pulse decoder: FSM state codes,
// default timing constants and a small elaboration helper.
package onehot_pulse_decoder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int DEFAULT_HOLD = 4;
  localparam int DEFAULT_GAP  = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder_bin2onehot.sv
// Combinational CODE_W-to-N_OUT decoder with an in-range flag for codes
// that have no matching output line.
module bin2onehot #(
  parameter int N_OUT  = 8,
  parameter int CODE_W = $clog2(N_OUT)
) (
  input  logic [CODE_W-1:0] code,
  output logic [N_OUT-1:0]  onehot,
  output logic              in_range
);

  // N_OUT never exceeds 2**CODE_W, so it fits in CODE_W+1 bits.
  assign in_range = ({1'b0, code} < (CODE_W + 1)'(N_OUT));

  always_comb begin
    // NOTE: assign a default before the loop so no bit is left unassigned on any path (no latch).
    onehot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      onehot[i] = (code == CODE_W'(i));
    end
  end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Sequential binary-to-one-hot decoder: each accepted index drives one line
// for HOLD cycles, followed by GAP all-zero guard cycles.
module onehot_pulse_decoder
  import onehot_pulse_decoder_pkg::*;
#(
  parameter int N_OUT  = 8,
  parameter int CODE_W = $clog2(N_OUT),
  parameter int HOLD   = DEFAULT_HOLD,
  parameter int GAP    = DEFAULT_GAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              abort,
  output logic [N_OUT-1:0]  out,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(max_int(HOLD, GAP) + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [N_OUT-1:0] dec;
  logic             dec_ok;
  logic             accept;

  bin2onehot #(
    .N_OUT  (N_OUT),
    .CODE_W (CODE_W)
  ) u_dec (
    .code     (code_in),
    .onehot   (dec),
    .in_range (dec_ok)
  );

  // Reset leaves state at ST_IDLE, so code_ready is already high during reset.
  assign code_ready = (state == ST_IDLE) && !abort;
  assign accept     = code_valid && code_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      out   <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      err <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        cnt   <= '0;
        out   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (dec_ok) begin
                out   <= dec;
                busy  <= 1'b1;
                state <= ST_HOLD;
                cnt   <= HOLD_LD;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (cnt == '0) begin
              out <= '0;
              if (GAP > 0) begin
                state <= ST_GAP;
                cnt   <= GAP_LD;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_GAP: begin
            if (cnt == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            out   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Self-checking bench: three decoder variants (defaults, N_OUT=6, HOLD=1/GAP=0)
// share one stimulus stream and are compared against a cycle-timeline model.
module tb_onehot_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] code_in;
  logic       code_valid;
  logic       abort;

  logic [7:0] out_a;
  logic [5:0] out_b;
  logic [7:0] out_c;
  logic       ready_a, ready_b, ready_c;
  logic       busy_a, busy_b, busy_c;
  logic       err_a, err_b, err_c;

  always #5 clk = ~clk;

  onehot_pulse_decoder #(.N_OUT(8), .HOLD(4), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(ready_a), .abort(abort), .out(out_a), .busy(busy_a), .err(err_a)
  );

  onehot_pulse_decoder #(.N_OUT(6), .HOLD(4), .GAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(ready_b), .abort(abort), .out(out_b), .busy(busy_b), .err(err_b)
  );

  onehot_pulse_decoder #(.N_OUT(8), .HOLD(1), .GAP(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(ready_c), .abort(abort), .out(out_c), .busy(busy_c), .err(err_c)
  );

  logic [7:0] obs_out[3];
  logic       obs_ready[3], obs_busy[3], obs_err[3];
  assign obs_out[0] = out_a;
  assign obs_out[1] = {2'b00, out_b};
  assign obs_out[2] = out_c;
  assign obs_ready[0] = ready_a;
  assign obs_ready[1] = ready_b;
  assign obs_ready[2] = ready_c;
  assign obs_busy[0] = busy_a;
  assign obs_busy[1] = busy_b;
  assign obs_busy[2] = busy_c;
  assign obs_err[0] = err_a;
  assign obs_err[1] = err_b;
  assign obs_err[2] = err_c;

  // Model: per variant, cycles left until idle, cycles left with the line high.
  int         p_n[3] = '{8, 6, 8};
  int         p_h[3] = '{4, 4, 1};
  int         p_g[3] = '{1, 1, 0};
  int         m_busy_left[3];
  int         m_out_left[3];
  logic [7:0] m_val[3];
  logic       m_err[3];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy_left[k] = 0;
      m_out_left[k]  = 0;
      m_val[k]       = '0;
      m_err[k]       = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic acc, input logic [2:0] c, input logic a);
    m_err[k] = 1'b0;
    if (a) begin
      m_busy_left[k] = 0;
      m_out_left[k]  = 0;
    end else if (m_busy_left[k] > 0) begin
      m_busy_left[k]--;
      if (m_out_left[k] > 0) m_out_left[k]--;
    end else if (acc) begin
      if (int'(c) < p_n[k]) begin
        m_busy_left[k] = p_h[k] + p_g[k];
        m_out_left[k]  = p_h[k];
        m_val[k]       = 8'(1 << c);
      end else begin
        m_err[k] = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] model_out(input int k);
    return (m_out_left[k] > 0) ? m_val[k] : 8'h00;
  endfunction

  task automatic check_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_out%0d", tag, k), obs_out[k], model_out(k));
      check($sformatf("%s_busy%0d", tag, k), 8'(obs_busy[k]), 8'(m_busy_left[k] > 0));
      check($sformatf("%s_err%0d", tag, k), 8'(obs_err[k]), 8'(m_err[k]));
      check($sformatf("%s_onehot0_%0d", tag, k), 8'($onehot0(obs_out[k])), 8'h01);
    end
  endtask

  // One clock: drive at the falling edge, check ready, step model at the rising edge, check outputs.
  task automatic cycle(input logic v, input logic [2:0] c, input logic a);
    logic rdy[3];
    @(negedge clk);
    code_valid = v;
    code_in    = c;
    abort      = a;
    #1;
    for (int k = 0; k < 3; k++) begin
      rdy[k] = (m_busy_left[k] == 0) && !a;
      check($sformatf("ready%0d", k), 8'(obs_ready[k]), 8'(rdy[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, v && rdy[k], c, a);
    #1;
    check_outputs("cyc");
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_out%0d", tag, k), obs_out[k], 8'h00);
      check($sformatf("%s_busy%0d", tag, k), 8'(obs_busy[k]), 8'h00);
      check($sformatf("%s_err%0d", tag, k), 8'(obs_err[k]), 8'h00);
      check($sformatf("%s_ready%0d", tag, k), 8'(obs_ready[k]), 8'h01);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    code_in    = '0;
    code_valid = 1'b0;
    abort      = 1'b0;
    model_reset();
    #3;
    check_reset_state("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single decode of 5 with default timing.
    cycle(1'b1, 3'd5, 1'b0);
    check("single_t1", out_a, 8'h20);
    cycle(1'b0, 3'd1, 1'b0);
    cycle(1'b0, 3'd1, 1'b0);
    cycle(1'b0, 3'd1, 1'b0);
    check("single_t4", out_a, 8'h20);
    cycle(1'b0, 3'd1, 1'b0);
    check("single_t5_out", out_a, 8'h00);
    check("single_t5_busy", 8'(busy_a), 8'h01);
    cycle(1'b0, 3'd1, 1'b0);
    check("single_t6_busy", 8'(busy_a), 8'h00);
    check("single_t6_ready", 8'(ready_a), 8'h01);

    // Back-to-back with valid held: 0 then 7.
    cycle(1'b1, 3'd0, 1'b0);
    check("b2b_first", out_a, 8'h01);
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'd7, 1'b0);
    check("b2b_gap", out_a, 8'h00);
    cycle(1'b1, 3'd7, 1'b0);
    check("b2b_second", out_a, 8'h80);
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 1'b0);

    // Abort during HOLD beats a simultaneous valid.
    cycle(1'b1, 3'd3, 1'b0);
    check("abort_t1", out_a, 8'h08);
    cycle(1'b0, 3'd3, 1'b0);
    cycle(1'b1, 3'd6, 1'b1);
    check("abort_out", out_a, 8'h00);
    check("abort_busy", 8'(busy_a), 8'h00);
    cycle(1'b1, 3'd6, 1'b0);
    check("abort_next", out_a, 8'h40);
    cycle(1'b1, 3'd6, 1'b1);

    // Out-of-range code on the N_OUT=6 variant.
    cycle(1'b1, 3'd7, 1'b0);
    check("oor_err", 8'(err_b), 8'h01);
    check("oor_out", {2'b00, out_b}, 8'h00);
    cycle(1'b0, 3'd7, 1'b0);
    check("oor_err_clear", 8'(err_b), 8'h00);
    cycle(1'b1, 3'd5, 1'b1);
    cycle(1'b1, 3'd5, 1'b0);
    check("oor_then_5", {2'b00, out_b}, 8'h20);
    cycle(1'b1, 3'd5, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
    end

    // Reset in the middle of a HOLD.
    cycle(1'b0, 3'd0, 1'b1);
    cycle(1'b1, 3'd4, 1'b0);
    cycle(1'b0, 3'd4, 1'b0);
    check("rst_pre", out_a, 8'h10);
    @(negedge clk);
    code_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 3'd2, 1'b0);
    check("rst_post", out_a, 8'h04);
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/onehot_pulse_decoder.md
Name: onehot_pulse_decoder

Overview:
- Sequential binary-to-one-hot decoder; the inverse of the team's 8:3 priority encoder.
- Accepts a binary index over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. All outputs then return to zero for a guard gap before the next index is accepted.
- Sits on the select/grant side of arbitration and enable logic, downstream of encoders that produce the index.

Parameters:
- N_OUT, 8, number of one-hot output lines; legal range 2..256.
- CODE_W, $clog2(N_OUT), width of the binary index.
- HOLD, 4, cycles the one-hot output is held per accepted index; minimum 1.
- GAP, 1, all-zero guard cycles after each hold; minimum 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- code_in  input  CODE_W  binary index to decode.
- code_valid  input  1  code_in is valid this cycle.
- code_ready  output  1  block can accept an index this cycle.
- abort  input  1  synchronous flush of any hold or gap in progress.
- out  output  N_OUT  one-hot decoded lines, registered.
- busy  output  1  high in HOLD or GAP, registered.
- err  output  1  one-cycle pulse when an out-of-range index is accepted, registered.

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n low, asynchronous):
  - out=0, busy=0, err=0, state=IDLE, counter=0.
  - code_ready reads 1 while in reset because it is combinational from state.
- code_ready = (state==IDLE) & ~abort, combinational.
- Acceptance: a rising edge with code_valid & code_ready.
- States: IDLE, HOLD, GAP.
- IDLE, on accept at edge T, with code_in < N_OUT:
  - from T+1: out = 1<<code_in, busy=1, state=HOLD, counter=HOLD-1.
- IDLE, on accept of code_in >= N_OUT (only possible when N_OUT is not a power of 2):
  - out stays 0 and state stays IDLE.
  - err=1 for exactly one cycle after T.
- HOLD:
  - out is held constant and the counter decrements.
  - When the counter reaches 0: go to GAP with counter=GAP-1 if GAP>0, else go to IDLE.
  - On that exit edge out goes to 0.
  - The one-hot output is therefore high for exactly HOLD cycles.
- GAP:
  - out=0, busy=1, counter decrements.
  - When the counter reaches 0, go to IDLE with busy=0.
- Throughput: with continuous valid, one index per HOLD+GAP+1 cycles.
  - Defaults: out high on cycles T+1..T+4, zero on T+5, back in IDLE at T+6, next out at T+7.
- abort:
  - From any state, the next edge gives out=0, busy=0, state IDLE, counter=0.
  - abort beats a simultaneous code_valid; that index is not accepted because code_ready is 0.
  - abort in IDLE has no effect other than deasserting code_ready for that cycle.
- code_in changes while not accepted are ignored; out never changes except at accept, hold end, or abort.
- out is always all-zero or exactly one-hot; a multi-hot value is a design error.
- Counter width is $clog2(max(HOLD,GAP)+1). No wrap-around is possible because the counter is reloaded on every state entry.
- Reset mid-HOLD or mid-GAP clears everything immediately, with no glitch on out beyond the asynchronous clear.

Decomposition:
- Shared package: state enum (IDLE, HOLD, GAP) and the default HOLD and GAP constants.
- One natural sub-module: bin2onehot, a purely combinational CODE_W-to-N_OUT decoder.
  - It also produces an in_range flag.
  - Its output feeds the out register and the err logic.

Test Plan:
- Reset check: rst_n low mid-HOLD with out=8'h10 -> out=0, busy=0, code_ready=1 immediately; after release, accept code 2 -> out=8'h04 on the next cycle.
- Single decode with defaults: code_in=5, valid one cycle at T -> out=8'h20 on T+1..T+4, 0 at T+5, busy falls at T+6, code_ready=1 at T+6.
- Back-to-back with valid held: codes 0 then 7 -> out=8'h01 for 4 cycles, a 1-cycle zero gap, then ready, then out=8'h80 for 4 cycles; 0 accepted on IDLE cycles only.
- abort during HOLD: accept 3, assert abort at T+2 with valid=1 and code 6 -> out=0 at T+3, code 6 not accepted, next IDLE cycle with valid accepts 6.
- Out-of-range with N_OUT=6: code_in=7 accepted -> err=1 for one cycle, out stays 0, code_ready stays 1; code_in=5 -> out=6'b100000.
- Corner parameters HOLD=1, GAP=0: repeated valid -> out high for 1 cycle out of every 2, and out is never multi-hot (assertion).
